vga_sync_decoder: RTL

- Receiving end of the CRT timing interface: accepts active-low hsync/vsync and a pixel-enable strobe, and measures line/frame timing.
- Regenerates synchronized (xpos, ypos) coordinates and an active-video flag.
- Declares lock once timing is stable for a set number of frames.
- Sits downstream of the CRT controller (bench checker, or front end of a frame-capture path) on the same system clock.

---
 rtl/vga_sync_decoder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// Receive side of the CRT timing interface: measures line/frame timing from
// active-low hsync/vsync and regenerates active-video coordinates and lock.
//
// state  | meaning
// SEARCH | measuring; counting consecutive identical frames toward lock
// LOCKED | timing stable; any measurement change or counter overflow drops out
module vga_sync_decoder #(
  parameter int CountSize  = 10,
  parameter int LockFrames = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 PixelEnable,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic [CountSize-1:0] hSynchPulse,
  input  logic [CountSize-1:0] hBackPorch,
  input  logic [CountSize-1:0] Xresolution,
  input  logic [CountSize-1:0] vSynchPulse,
  input  logic [CountSize-1:0] vBackPorch,
  input  logic [CountSize-1:0] Yresolution,
  output logic [CountSize-1:0] hTotal,
  output logic [CountSize-1:0] hSyncWidth,
  output logic [CountSize-1:0] vTotal,
  output logic [CountSize-1:0] vSyncWidth,
  output logic [CountSize-1:0] xpos,
  output logic [CountSize-1:0] ypos,
  output logic                 videoActive,
  output logic                 lineStart,
  output logic                 frameStart,
  output logic                 locked,
  output logic                 timingError
);
  localparam int MatchW = (LockFrames < 1) ? 1 : $clog2(LockFrames + 1);
  localparam logic [CountSize-1:0] CntMax     = '1;
  localparam logic [CountSize-1:0] CntOne     = CountSize'(1);
  localparam logic [CountSize-1:0] CntNearMax = CntMax - CntOne;
  localparam logic [MatchW-1:0]    MatchOne   = MatchW'(1);
  localparam logic [MatchW-1:0]    MatchGoal  = MatchW'(LockFrames);

  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t state;

  logic                 hs_prev, vs_prev, primed;
  logic                 h_seen, v_seen, h_valid, v_valid, dirty;
  logic [MatchW-1:0]    match_cnt;
  logic [CountSize-1:0] hcnt, vcnt;

  logic                 h_fall, h_rise, v_fall, v_rise;
  logic                 h_sat, v_sat, h_changed, v_changed, frame_match;
  logic [CountSize-1:0] h_meas, v_meas;
  logic [CountSize:0]   hoff, hend, voff, vend;
  logic                 x_act, y_act;

  // The first enabled sample after reset only loads the history, so a sync
  // already low at release never looks like an edge.
  assign h_fall = PixelEnable & primed & hs_prev & ~hsync;
  assign h_rise = PixelEnable & primed & ~hs_prev & hsync;
  assign v_fall = h_fall & vs_prev & ~vsync;
  assign v_rise = h_fall & ~vs_prev & vsync;

  // Counters read 0 on the edge sample, so the span is the count plus one.
  assign h_meas = (hcnt == CntMax) ? hcnt : hcnt + CntOne;
  assign v_meas = (vcnt == CntMax) ? vcnt : vcnt + CntOne;

  assign h_sat = PixelEnable & ~h_fall & (hcnt == CntNearMax);
  assign v_sat = h_fall & ~v_fall & (vcnt == CntNearMax);

  assign h_changed   = h_fall & h_valid & (h_meas != hTotal);
  assign v_changed   = v_fall & v_valid & (v_meas != vTotal);
  assign frame_match = v_valid & ~dirty & ~h_changed & (v_meas == vTotal);

  assign hoff  = {1'b0, hSynchPulse} + {1'b0, hBackPorch};
  assign hend  = hoff + {1'b0, Xresolution};
  assign voff  = {1'b0, vSynchPulse} + {1'b0, vBackPorch};
  assign vend  = voff + {1'b0, Yresolution};
  assign x_act = ({1'b0, hcnt} >= hoff) && ({1'b0, hcnt} < hend);
  assign y_act = ({1'b0, vcnt} >= voff) && ({1'b0, vcnt} < vend);

  always_ff @(posedge clock) begin
    if (reset) begin
      hTotal      <= '0;
      hSyncWidth  <= '0;
      vTotal      <= '0;
      vSyncWidth  <= '0;
      xpos        <= '0;
      ypos        <= '0;
      videoActive <= 1'b0;
      lineStart   <= 1'b0;
      frameStart  <= 1'b0;
      locked      <= 1'b0;
      timingError <= 1'b0;
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      primed      <= 1'b0;
      h_seen      <= 1'b0;
      v_seen      <= 1'b0;
      h_valid     <= 1'b0;
      v_valid     <= 1'b0;
      dirty       <= 1'b0;
      match_cnt   <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      state       <= SEARCH;
    end else begin
      lineStart   <= 1'b0;
      frameStart  <= 1'b0;
      timingError <= 1'b0;
      xpos        <= x_act ? hcnt - hoff[CountSize-1:0] : '0;
      ypos        <= y_act ? vcnt - voff[CountSize-1:0] : '0;
      videoActive <= x_act & y_act;

      if (PixelEnable) begin
        primed  <= 1'b1;
        hs_prev <= hsync;

        if (h_fall) begin
          hcnt      <= '0;
          lineStart <= 1'b1;
          h_seen    <= 1'b1;
          vs_prev   <= vsync;
          if (h_seen) begin
            hTotal  <= h_meas;
            h_valid <= 1'b1;
          end
          if (v_fall) begin
            vcnt       <= '0;
            frameStart <= 1'b1;
            v_seen     <= 1'b1;
            if (v_seen) begin
              vTotal  <= v_meas;
              v_valid <= 1'b1;
            end
          end else begin
            if (v_rise && v_seen) vSyncWidth <= v_meas;
            if (vcnt != CntMax) vcnt <= vcnt + CntOne;
          end
        end else begin
          if (h_rise && h_seen) hSyncWidth <= h_meas;
          if (hcnt != CntMax) hcnt <= hcnt + CntOne;
        end

        // A line-length change anywhere in a frame disqualifies that frame.
        if (v_fall) dirty <= 1'b0;
        else if (h_changed) dirty <= 1'b1;

        case (state)
          SEARCH: begin
            if (v_fall && v_seen) begin
              if (frame_match) begin
                if (match_cnt + MatchOne == MatchGoal) begin
                  state     <= LOCKED;
                  locked    <= 1'b1;
                  match_cnt <= '0;
                end else begin
                  match_cnt <= match_cnt + MatchOne;
                end
              end else begin
                match_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if (h_changed || v_changed) begin
              timingError <= 1'b1;
              locked      <= 1'b0;
              match_cnt   <= '0;
              state       <= SEARCH;
            end
          end
          default: state <= SEARCH;
        endcase

        if (h_sat || v_sat) begin
          timingError <= 1'b1;
          locked      <= 1'b0;
          match_cnt   <= '0;
          state       <= SEARCH;
        end
      end
    end
  end
endmodule
